// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: screen geometry, address/pixel widths,
// background colour and the write-port state encoding. Used by the write
// arbiter, the line drawer and the trace controller.
package fb_pkg;

  localparam int FB_WIDTH    = 640;
  localparam int FB_HEIGHT   = 480;
  localparam int FB_ADDR_W   = 19;
  localparam int FB_PIXEL_W  = 1;
  localparam int FB_BG_COLOR = 0;
  localparam int FB_PIXELS   = FB_WIDTH * FB_HEIGHT;
  localparam int FB_COORD_W  = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

  // Linear framebuffer address of pixel (x,y) for a screen 'width' pixels wide.
  // Callers truncate the result to their address width.
  function automatic int unsigned fb_linear_addr(input logic [FB_COORD_W-1:0] x,
                                                 input logic [FB_COORD_W-1:0] y,
                                                 input int unsigned           width);
    return (32'(y) * width) + 32'(x);
  endfunction

endpackage

// File: rtl/fb_clear_seq.sv
// Full-screen clear sequencer: once started it walks an address counter from
// 0 to PIXELS-1, one address per cycle, then stops. A start while running is
// ignored. o_last marks the cycle presenting the final address.
module fb_clear_seq
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int PIXELS = FB_PIXELS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  logic              r_busy;
  logic [ADDR_W-1:0] r_addr;

  // Address counter: restart at 0 on start, step while busy, park on the last address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_addr <= '0;
    end else if (r_busy) begin
      if (r_addr == LAST_ADDR) begin
        r_busy <= 1'b0;
      end else begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_addr <= '0;
    end
  end

  assign o_busy = r_busy;
  assign o_addr = r_addr;
  assign o_last = r_busy && (r_addr == LAST_ADDR);

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port owner. Shares the single write port between the line
// drawer (ln_*), the overlay generator (gr_*) and the full-screen clear
// sequencer, converting (x,y) to y*WIDTH+x with one write per cycle.
// Optional build macro FB_CLIP_EN: out-of-range pixels are accepted but
// dropped and raise the sticky clip flag; without it no range check is made.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int                 WIDTH    = FB_WIDTH,
  parameter int                 HEIGHT   = FB_HEIGHT,
  parameter int                 ADDR_W   = FB_ADDR_W,
  parameter int                 PIXEL_W  = FB_PIXEL_W,
  parameter logic [PIXEL_W-1:0] BG_COLOR = PIXEL_W'(FB_BG_COLOR)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clear_req,
  output logic                  o_clear_busy,
  output logic                  o_clear_done,
  input  logic                  i_ln_valid,
  output logic                  o_ln_ready,
  input  logic [FB_COORD_W-1:0] i_ln_x,
  input  logic [FB_COORD_W-1:0] i_ln_y,
  input  logic [PIXEL_W-1:0]    i_ln_color,
  input  logic                  i_gr_valid,
  output logic                  o_gr_ready,
  input  logic [FB_COORD_W-1:0] i_gr_x,
  input  logic [FB_COORD_W-1:0] i_gr_y,
  input  logic [PIXEL_W-1:0]    i_gr_color,
  output logic                  o_fb_we,
  output logic [ADDR_W-1:0]     o_fb_addr,
  output logic [PIXEL_W-1:0]    o_fb_data,
  output logic                  o_clip_flag
);

  localparam int PIXELS = WIDTH * HEIGHT;

  fb_state_e            r_state;
  logic                 r_fb_we;
  logic [ADDR_W-1:0]    r_fb_addr;
  logic [PIXEL_W-1:0]   r_fb_data;
  logic                 r_clear_done;
  logic                 r_prio_ln;

  logic                  w_clr_start;
  logic                  w_clr_busy;
  logic                  w_clr_last;
  logic [ADDR_W-1:0]     w_clr_addr;
  logic                  w_arb_open;
  logic                  w_contended;
  logic                  w_ln_grant;
  logic                  w_gr_grant;
  logic                  w_any_grant;
  logic [FB_COORD_W-1:0] w_sel_x;
  logic [FB_COORD_W-1:0] w_sel_y;
  logic [PIXEL_W-1:0]    w_sel_color;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic                  w_sel_clip;

  // A clear request only starts the sequencer from IDLE; repeats mid-clear are dropped.
  assign w_clr_start = (r_state == ST_IDLE) && i_clear_req;

  fb_clear_seq #(
    .ADDR_W (ADDR_W),
    .PIXELS (PIXELS)
  ) u_clear_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (w_clr_start),
    .o_busy  (w_clr_busy),
    .o_addr  (w_clr_addr),
    .o_last  (w_clr_last)
  );

  // Pixel arbitration: clear wins over pixels, contention goes to the pointer side.
  assign w_arb_open  = (r_state == ST_IDLE) && !i_clear_req;
  assign w_contended = i_ln_valid && i_gr_valid;
  assign w_ln_grant  = w_arb_open && i_ln_valid && (!i_gr_valid || r_prio_ln);
  assign w_gr_grant  = w_arb_open && i_gr_valid && (!i_ln_valid || !r_prio_ln);
  assign w_any_grant = w_ln_grant || w_gr_grant;
  assign o_ln_ready  = w_ln_grant;
  assign o_gr_ready  = w_gr_grant;

  // Granted pixel and its linear address.
  assign w_sel_x     = w_gr_grant ? i_gr_x : i_ln_x;
  assign w_sel_y     = w_gr_grant ? i_gr_y : i_ln_y;
  assign w_sel_color = w_gr_grant ? i_gr_color : i_ln_color;
  assign w_sel_addr  = ADDR_W'(fb_linear_addr(w_sel_x, w_sel_y, WIDTH));

`ifdef FB_CLIP_EN
  logic r_clip_flag;

  assign w_sel_clip = (32'(w_sel_x) >= 32'(WIDTH)) || (32'(w_sel_y) >= 32'(HEIGHT));

  // Sticky clip indicator: set by a dropped off-screen pixel, cleared by a clear request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clip_flag <= 1'b0;
    end else if (i_clear_req) begin
      r_clip_flag <= 1'b0;
    end else if (w_any_grant && w_sel_clip) begin
      r_clip_flag <= 1'b1;
    end
  end

  assign o_clip_flag = r_clip_flag;
`else
  assign w_sel_clip  = 1'b0;
  assign o_clip_flag = 1'b0;
`endif

  // Write-port FSM: registers pixel writes in IDLE, tracks the clear and pulses done at its end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_fb_we      <= 1'b0;
      r_fb_addr    <= '0;
      r_fb_data    <= '0;
      r_clear_done <= 1'b0;
      r_prio_ln    <= 1'b1;
    end else begin
      r_fb_we      <= 1'b0;
      r_clear_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_clear_req) begin
            r_state <= ST_CLEAR;
          end else if (w_any_grant) begin
            if (!w_sel_clip) begin
              r_fb_we   <= 1'b1;
              r_fb_addr <= w_sel_addr;
              r_fb_data <= w_sel_color;
            end
            if (w_contended) begin
              r_prio_ln <= !r_prio_ln;
            end
          end
        end
        ST_CLEAR: begin
          if (w_clr_last) begin
            r_state      <= ST_IDLE;
            r_clear_done <= 1'b1;
            r_fb_addr    <= w_clr_addr;
            r_fb_data    <= BG_COLOR;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // While clearing, the sequencer's registered address drives the port directly.
  assign o_fb_we      = r_fb_we || w_clr_busy;
  assign o_fb_addr    = w_clr_busy ? w_clr_addr : r_fb_addr;
  assign o_fb_data    = w_clr_busy ? BG_COLOR : r_fb_data;
  assign o_clear_busy = w_clr_busy;
  assign o_clear_done = r_clear_done;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Testbench for fb_write_arbiter on a reduced 20x12 screen so full clears stay short.
// Expected writes and clear_done pulses are queued by a reference model when
// stimulus is applied; a negedge monitor pops and compares them.
module tb_fb_write_arbiter;

  localparam int W      = 20;
  localparam int H      = 12;
  localparam int PIX    = W * H;
  localparam int AW     = 19;
  localparam int PW     = 2;
  localparam logic [PW-1:0] BG = 2'b10;

  typedef struct {
    int              cyc;
    logic [AW-1:0]   addr;
    logic [PW-1:0]   data;
    bit              isClr;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clearReq = 1'b0;
  logic          clearBusy;
  logic          clearDone;
  logic          lnValid = 1'b0;
  logic          lnReady;
  logic [9:0]    lnX = '0;
  logic [9:0]    lnY = '0;
  logic [PW-1:0] lnColor = '0;
  logic          grValid = 1'b0;
  logic          grReady;
  logic [9:0]    grX = '0;
  logic [9:0]    grY = '0;
  logic [PW-1:0] grColor = '0;
  logic          fbWe;
  logic [AW-1:0] fbAddr;
  logic [PW-1:0] fbData;
  logic          clipFlag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  wr_t expQ[$];
  int  doneQ[$];
  int  mClearEnd = -1;
  bit  mLnNext = 1'b1;
  bit  mClip = 1'b0;
  logic [AW-1:0] holdAddr = '0;
  logic [PW-1:0] holdData = '0;

  fb_write_arbiter #(
    .WIDTH    (W),
    .HEIGHT   (H),
    .ADDR_W   (AW),
    .PIXEL_W  (PW),
    .BG_COLOR (BG)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear_req  (clearReq),
    .o_clear_busy (clearBusy),
    .o_clear_done (clearDone),
    .i_ln_valid   (lnValid),
    .o_ln_ready   (lnReady),
    .i_ln_x       (lnX),
    .i_ln_y       (lnY),
    .i_ln_color   (lnColor),
    .i_gr_valid   (grValid),
    .o_gr_ready   (grReady),
    .i_gr_x       (grX),
    .i_gr_y       (grY),
    .i_gr_color   (grColor),
    .o_fb_we      (fbWe),
    .o_fb_addr    (fbAddr),
    .o_fb_data    (fbData),
    .o_clip_flag  (clipFlag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: a pixel accepted in cycle n lands at (y*W+x) mod 2^AW in cycle n+1.
  task automatic modelPixel(input int n, input logic [9:0] x, input logic [9:0] y, input logic [PW-1:0] c);
    wr_t e;
    int unsigned lin;
`ifdef FB_CLIP_EN
    if (x >= W || y >= H) begin
      mClip = 1'b1;
      return;
    end
`endif
    lin     = (int'(y) * W + int'(x)) % (1 << AW);
    e.cyc   = n + 1;
    e.addr  = AW'(lin);
    e.data  = c;
    e.isClr = 1'b0;
    expQ.push_back(e);
  endtask

  // Reference model: a clear accepted in cycle n writes addresses 0..PIX-1 in cycles n+1..n+PIX.
  task automatic modelClear(input int n);
    wr_t e;
    for (int i = 0; i < PIX; i++) begin
      e.cyc   = n + 1 + i;
      e.addr  = AW'(i);
      e.data  = BG;
      e.isClr = 1'b1;
      expQ.push_back(e);
    end
    doneQ.push_back(n + PIX + 1);
    mClearEnd = n + PIX;
  endtask

  // One clock cycle of stimulus, entered and left 1 time unit after a rising edge.
  task automatic applyStimulus(input bit clr,
                               input bit lnV, input logic [9:0] lx, input logic [9:0] ly, input logic [PW-1:0] lc,
                               input bit grV, input logic [9:0] gx, input logic [9:0] gy, input logic [PW-1:0] gc,
                               output bit lnAcc, output bit grAcc);
    int n;
    bit open;
    n        = cyc;
    clearReq = clr;
    lnValid  = lnV; lnX = lx; lnY = ly; lnColor = lc;
    grValid  = grV; grX = gx; grY = gy; grColor = gc;
    open  = (n > mClearEnd) && !clr;
    lnAcc = 1'b0;
    grAcc = 1'b0;
    if (open && lnV && grV) begin
      lnAcc   = mLnNext;
      grAcc   = !mLnNext;
      mLnNext = !mLnNext;
    end else if (open) begin
      lnAcc = lnV;
      grAcc = grV;
    end
    #3;
    checkOutput("ln_ready", lnReady, lnAcc);
    checkOutput("gr_ready", grReady, grAcc);
    checkOutput("clip_flag", clipFlag, mClip);
    if (lnAcc) modelPixel(n, lx, ly, lc);
    if (grAcc) modelPixel(n, gx, gy, gc);
    if (clr) begin
      mClip = 1'b0;
      if (n > mClearEnd) modelClear(n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int k);
    bit a, b;
    for (int i = 0; i < k; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, a, b);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_fb_we", fbWe, 0);
    checkOutput("rst_fb_addr", fbAddr, 0);
    checkOutput("rst_fb_data", fbData, 0);
    checkOutput("rst_clear_busy", clearBusy, 0);
    checkOutput("rst_clear_done", clearDone, 0);
    checkOutput("rst_clip_flag", clipFlag, 0);
  endtask

  // Asynchronous reset in the middle of a cycle; any pending model work is dropped.
  task automatic doReset();
    clearReq = 1'b0; lnValid = 1'b0; grValid = 1'b0;
    reset_n  = 1'b0;
    expQ.delete();
    doneQ.delete();
    mClearEnd = -1;
    mLnNext   = 1'b1;
    mClip     = 1'b0;
    holdAddr  = '0;
    holdData  = '0;
    #3;
    checkResetValues();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [9:0] randCoord(input int lim);
    if ($urandom_range(0, 7) == 0) return 10'($urandom_range(lim, 1023));
    return 10'($urandom_range(0, lim - 1));
  endfunction

  // Monitor: every cycle either a queued write appears or the port holds its last write.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        checks++; errors++;
        $display("[TB] FAIL write_missing cyc=%0d expected addr=%0d at cyc=%0d", cyc, expQ[0].addr, expQ[0].cyc);
        holdAddr = expQ[0].addr;
        holdData = expQ[0].data;
        void'(expQ.pop_front());
      end
      while (doneQ.size() > 0 && doneQ[0] < cyc) begin
        checks++; errors++;
        $display("[TB] FAIL clear_done_missing cyc=%0d expected at cyc=%0d", cyc, doneQ[0]);
        void'(doneQ.pop_front());
      end
      checks++;
      if (fbWe === 1'b1) begin
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL write_unexpected cyc=%0d addr=%0d data=%0d", cyc, fbAddr, fbData);
        end else begin
          wr_t e;
          e = expQ.pop_front();
          if (e.cyc != cyc || fbAddr !== e.addr || fbData !== e.data || clearBusy !== e.isClr) begin
            errors++;
            $display("[TB] FAIL write cyc=%0d actual addr=%0d data=%0d busy=%0b, expected cyc=%0d addr=%0d data=%0d busy=%0b",
                     cyc, fbAddr, fbData, clearBusy, e.cyc, e.addr, e.data, e.isClr);
          end
          holdAddr = e.addr;
          holdData = e.data;
        end
      end else if (fbWe !== 1'b0 || fbAddr !== holdAddr || fbData !== holdData || clearBusy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_hold cyc=%0d actual we=%0b addr=%0d data=%0d busy=%0b, expected we=0 addr=%0d data=%0d busy=0",
                 cyc, fbWe, fbAddr, fbData, clearBusy, holdAddr, holdData);
      end
      if (clearDone !== 1'b0) begin
        checks++;
        if (doneQ.size() == 0 || doneQ[0] != cyc) begin
          errors++;
          $display("[TB] FAIL clear_done_unexpected cyc=%0d actual=%0b expected=0", cyc, clearDone);
        end else begin
          void'(doneQ.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit a, b, lnPend, grPend;
    int waitCnt;
    logic [9:0] px, py, qx, qy;
    logic [PW-1:0] pc, qc;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    checkOutput("rst_ln_ready", lnReady, 0);
    reset_n = 1'b1;

    // Single line-drawer pixel (3,2): address 2*W+3 one cycle later.
    applyStimulus(1'b0, 1'b1, 10'd3, 10'd2, 2'd1, 1'b0, '0, '0, '0, a, b);
    checkOutput("t1_fb_we", fbWe, 1);
    checkOutput("t1_fb_addr", fbAddr, 2 * W + 3);
    checkOutput("t1_fb_data", fbData, 1);
    idleCycles(2);

    // Both requesters valid for six cycles: grants alternate starting with ln.
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 1'b1, 10'(i), 10'd1, 2'd3, 1'b1, 10'(i + 10), 10'd9, 2'd2, a, b);
    idleCycles(2);

    // Clear requested while ln holds a pixel: ln stalls for the whole clear, then lands.
    waitCnt = 0;
    applyStimulus(1'b1, 1'b1, 10'd5, 10'd7, 2'd3, 1'b0, '0, '0, '0, a, b);
    if (!a) waitCnt++;
    while (!a && waitCnt < PIX + 20) begin
      applyStimulus(1'b0, 1'b1, 10'd5, 10'd7, 2'd3, 1'b0, '0, '0, '0, a, b);
      if (!a) waitCnt++;
    end
    checkOutput("t3_ln_stall_cycles", waitCnt, PIX + 1);
    idleCycles(3);

    // Clear requested again at clear write 100: no restart, one clear_done.
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, a, b);
    idleCycles(100);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, a, b);
    idleCycles(PIX + 5);

`ifdef FB_CLIP_EN
    // Off-screen pixel is accepted, dropped, and flags a clip until the next clear request.
    applyStimulus(1'b0, 1'b1, 10'(W), 10'd0, 2'd1, 1'b0, '0, '0, '0, a, b);
    checkOutput("t5_clip_set", clipFlag, 1);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, a, b);
    checkOutput("t5_clip_cleared", clipFlag, 0);
    idleCycles(PIX + 5);
`endif

    // Reset during a clear: no clear_done, and a fresh clear starts from address 0.
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, a, b);
    idleCycles(50);
    doReset();
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, a, b);
    idleCycles(PIX + 5);

    // Randomised traffic: requesters hold pixels until accepted, with occasional clears.
    lnPend = 1'b0; grPend = 1'b0;
    px = '0; py = '0; pc = '0; qx = '0; qy = '0; qc = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!lnPend && $urandom_range(0, 9) < 6) begin
        lnPend = 1'b1; px = randCoord(W); py = randCoord(H); pc = PW'($urandom());
      end
      if (!grPend && $urandom_range(0, 9) < 5) begin
        grPend = 1'b1; qx = randCoord(W); qy = randCoord(H); qc = PW'($urandom());
      end
      applyStimulus($urandom_range(0, 299) == 0, lnPend, px, py, pc, grPend, qx, qy, qc, a, b);
      if (a) lnPend = 1'b0;
      if (b) grPend = 1'b0;
    end
    idleCycles(PIX + 5);

    checkOutput("writes_outstanding", expQ.size(), 0);
    checkOutput("clear_done_outstanding", doneQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
